// File: rtl/ifm_enc_pkg.sv
// Shared definitions for the IFM sparse encoder.
// Holds the chunk geometry agreed with the compute cluster, the encoder
// FSM state type, and bit-counting helpers used by the beat compactor.
package ifm_enc_pkg;

  localparam int ENC_MEM_SIZE    = 256;
  localparam int ENC_BUS_SIZE    = 32;
  localparam int ENC_CHANNEL_NUM = 256;
  localparam int ENC_WR_CYC_NUM  = ENC_MEM_SIZE / ENC_BUS_SIZE;
  localparam int ENC_PW          = $clog2(ENC_BUS_SIZE + 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WAIT    = 2'd1,
    ST_SEND    = 2'd2
  } enc_state_e;

  // Number of set bits in a beat-wide map.
  function automatic logic [ENC_PW-1:0] popcount(input logic [ENC_BUS_SIZE-1:0] v);
    logic [ENC_PW-1:0] c;
    c = '0;
    for (int i = 0; i < ENC_BUS_SIZE; i++) c = c + ENC_PW'(v[i]);
    return c;
  endfunction

  // Number of set bits strictly below position idx (exclusive prefix sum).
  function automatic logic [ENC_PW-1:0] prefix_cnt(input logic [ENC_BUS_SIZE-1:0] v,
                                                   input int idx);
    logic [ENC_PW-1:0] c;
    c = '0;
    for (int i = 0; i < ENC_BUS_SIZE; i++)
      if (i < idx) c = c + ENC_PW'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/sparse_beat_compactor.sv
// Combinational compaction of one dense beat.
// Ports:
//   i_beat_idx : beat position within the chunk (sets global element index)
//   i_data     : dense bytes, byte b = element i_beat_idx*BUS_SIZE+b
//   o_map      : per-byte non-zero flag, forced 0 for padding elements
//   o_comp     : non-zero bytes packed from byte 0 upward, rest 0
//   o_pop      : number of non-zero bytes in the beat
module sparse_beat_compactor
  import ifm_enc_pkg::*;
#(
  parameter int BUS_SIZE    = ENC_BUS_SIZE,
  parameter int CHANNEL_NUM = ENC_CHANNEL_NUM,
  parameter int CW          = 3,
  localparam int PW         = $clog2(BUS_SIZE + 1),
  localparam int CB         = $clog2(BUS_SIZE * 8)
) (
  input  logic [CW-1:0]         i_beat_idx,
  input  logic [BUS_SIZE*8-1:0] i_data,
  output logic [BUS_SIZE-1:0]   o_map,
  output logic [BUS_SIZE*8-1:0] o_comp,
  output logic [PW-1:0]         o_pop
);

  always_comb begin
    o_map = '0;
    for (int b = 0; b < BUS_SIZE; b++)
      o_map[b] = (i_data[b*8 +: 8] != 8'h00) &&
                 ((int'(i_beat_idx) * BUS_SIZE + b) < CHANNEL_NUM);
  end

  // Each flagged byte lands at its exclusive prefix count, preserving order.
  always_comb begin
    o_comp = '0;
    for (int b = 0; b < BUS_SIZE; b++)
      if (o_map[b])
        o_comp[CB'(int'(prefix_cnt(ENC_BUS_SIZE'(o_map), b)) * 8) +: 8] = i_data[b*8 +: 8];
  end

  assign o_pop = PW'(popcount(ENC_BUS_SIZE'(o_map)));

endmodule

// File: rtl/ifm_sparse_encoder.sv
// Dense-to-sparse IFM encoder feeding the compute cluster write port.
// Buffers one chunk of dense beats, keeps a sparsemap and a packed non-zero
// byte array, then streams the chunk as WR_CYC_NUM write beats and flips the
// ping-pong bank select.
// Ports:
//   clk_i / rst_ni        : clock, async active-low reset
//   din_valid_i/ready_o   : dense beat handshake; din_last_i ends the chunk early
//   din_data_i            : dense bytes of one beat
//   send_en_i             : permission to write the current bank (seen in WAIT only)
//   ifm_sparsemap_o       : map bits of write beat ifm_wr_count_o
//   ifm_nonzero_data_o    : packed bytes of write beat, zero past nnz
//   ifm_wr_valid_o/count_o: write beat strobe and index
//   ifm_wr_sel_o          : ping-pong bank
//   chunk_done_o          : pulse alongside the last write beat
//   nnz_count_o           : non-zeros in the chunk being sent
//
// state      | meaning
// ST_COLLECT | accepting dense beats into the chunk buffer
// ST_WAIT    | chunk complete, waiting for send_en_i
// ST_SEND    | emitting write beats 0..WR_CYC_NUM-1
module ifm_sparse_encoder
  import ifm_enc_pkg::*;
#(
  parameter int MEM_SIZE    = ENC_MEM_SIZE,
  parameter int BUS_SIZE    = ENC_BUS_SIZE,
  parameter int CHANNEL_NUM = ENC_CHANNEL_NUM,
  localparam int WR_CYC_NUM = MEM_SIZE / BUS_SIZE,
  localparam int CW         = $clog2(WR_CYC_NUM),
  localparam int NW         = $clog2(MEM_SIZE + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  din_valid_i,
  output logic                  din_ready_o,
  input  logic [BUS_SIZE*8-1:0] din_data_i,
  input  logic                  din_last_i,
  input  logic                  send_en_i,
  output logic [BUS_SIZE-1:0]   ifm_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] ifm_nonzero_data_o,
  output logic                  ifm_wr_valid_o,
  output logic [CW-1:0]         ifm_wr_count_o,
  output logic                  ifm_wr_sel_o,
  output logic                  chunk_done_o,
  output logic [NW-1:0]         nnz_count_o
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam int PW = $clog2(BUS_SIZE + 1);

  enc_state_e r_state, w_state_nxt;

  logic                  r_rdy;
  logic [CW:0]           r_beat_cnt;
  logic [NW-1:0]         r_nnz;
  logic [NW-1:0]         r_nnz_out;
  logic [MEM_SIZE-1:0]   r_map_buf;
  logic [7:0]            r_pk_buf [MEM_SIZE];
  logic                  r_wr_valid;
  logic [CW-1:0]         r_wr_cnt;
  logic                  r_wr_sel;
  logic                  r_done;
  logic [BUS_SIZE-1:0]   r_map_o;
  logic [BUS_SIZE*8-1:0] r_data_o;

  logic                  w_accept;
  logic                  w_last_beat;
  logic                  w_send_start;
  logic                  w_send_end;
  logic [BUS_SIZE-1:0]   w_map;
  logic [BUS_SIZE*8-1:0] w_comp;
  logic [PW-1:0]         w_pop;
  logic [CW-1:0]         w_rd_beat;
  logic [BUS_SIZE-1:0]   w_rd_map;
  logic [BUS_SIZE*8-1:0] w_rd_data;
  logic                  w_wr_en   [BUS_SIZE];
  logic [AW-1:0]         w_wr_addr [BUS_SIZE];

  // Ready is registered so it stays low while reset is asserted.
  assign w_accept     = din_valid_i && r_rdy;
  assign w_last_beat  = din_last_i || (r_beat_cnt == (CW+1)'(WR_CYC_NUM - 1));
  assign w_send_start = (r_state == ST_WAIT) && send_en_i;
  assign w_send_end   = (r_state == ST_SEND) && (r_wr_cnt == CW'(WR_CYC_NUM - 1));

  sparse_beat_compactor #(
    .BUS_SIZE    (BUS_SIZE),
    .CHANNEL_NUM (CHANNEL_NUM),
    .CW          (CW)
  ) u_compactor (
    .i_beat_idx (r_beat_cnt[CW-1:0]),
    .i_data     (din_data_i),
    .o_map      (w_map),
    .o_comp     (w_comp),
    .o_pop      (w_pop)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_COLLECT;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: if (w_accept && w_last_beat) w_state_nxt = ST_WAIT;
      ST_WAIT:    if (send_en_i) w_state_nxt = ST_SEND;
      ST_SEND:    if (w_send_end) w_state_nxt = ST_COLLECT;
      default:    w_state_nxt = ST_COLLECT;
    endcase
  end

  // Output register is loaded one beat ahead: beat 0 on the send start edge,
  // beat cnt+1 on each SEND edge.
  assign w_rd_beat = (r_state == ST_SEND) ? (r_wr_cnt + CW'(1)) : '0;
  assign w_rd_map  = r_map_buf[AW'(int'(w_rd_beat) * BUS_SIZE) +: BUS_SIZE];

  // Packed buffer is never cleared, so stale bytes past nnz are masked here.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < BUS_SIZE; k++)
      if ((int'(w_rd_beat) * BUS_SIZE + k) < int'(r_nnz))
        w_rd_data[k*8 +: 8] = r_pk_buf[AW'(int'(w_rd_beat) * BUS_SIZE + k)];
  end

  always_comb begin
    for (int j = 0; j < BUS_SIZE; j++) begin
      w_wr_en[j]   = w_accept && (j < int'(w_pop));
      w_wr_addr[j] = AW'(int'(r_nnz) + j);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < BUS_SIZE; j++)
      if (w_wr_en[j]) r_pk_buf[w_wr_addr[j]] <= w_comp[j*8 +: 8];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdy      <= 1'b0;
      r_beat_cnt <= '0;
      r_nnz      <= '0;
      r_nnz_out  <= '0;
      r_map_buf  <= '0;
      r_wr_valid <= 1'b0;
      r_wr_cnt   <= '0;
      r_wr_sel   <= 1'b0;
      r_done     <= 1'b0;
      r_map_o    <= '0;
      r_data_o   <= '0;
    end else begin
      r_rdy <= (w_state_nxt == ST_COLLECT);
      if (w_accept) begin
        r_map_buf[AW'(int'(r_beat_cnt[CW-1:0]) * BUS_SIZE) +: BUS_SIZE] <= w_map;
        r_nnz      <= r_nnz + NW'(w_pop);
        r_nnz_out  <= r_nnz + NW'(w_pop);
        r_beat_cnt <= r_beat_cnt + (CW+1)'(1);
      end
      if (w_send_start) begin
        r_wr_valid <= 1'b1;
        r_wr_cnt   <= '0;
        r_map_o    <= w_rd_map;
        r_data_o   <= w_rd_data;
        r_done     <= (WR_CYC_NUM == 1);
      end else if (r_state == ST_SEND) begin
        if (w_send_end) begin
          r_wr_valid <= 1'b0;
          r_wr_cnt   <= '0;
          r_done     <= 1'b0;
          r_map_o    <= '0;
          r_data_o   <= '0;
          r_wr_sel   <= ~r_wr_sel;
          r_beat_cnt <= '0;
          r_nnz      <= '0;
          r_map_buf  <= '0;
        end else begin
          r_wr_cnt <= r_wr_cnt + CW'(1);
          r_map_o  <= w_rd_map;
          r_data_o <= w_rd_data;
          r_done   <= (r_wr_cnt == CW'(WR_CYC_NUM - 2));
        end
      end
    end
  end

  assign din_ready_o        = r_rdy;
  assign ifm_sparsemap_o    = r_map_o;
  assign ifm_nonzero_data_o = r_data_o;
  assign ifm_wr_valid_o     = r_wr_valid;
  assign ifm_wr_count_o     = r_wr_cnt;
  assign ifm_wr_sel_o       = r_wr_sel;
  assign chunk_done_o       = r_done;
  assign nnz_count_o        = r_nnz_out;

endmodule
